// File: rtl/axi4m_burst.sv
// axi4m_burst: native command / write-beat / read-beat streams to a single
// AXI4 INCR burst per command (1..2^LEN_W beats).
// Optional feature macro: AXI4M_BURST_RESP_ERR_EN enables the err output.
// With the macro undefined, err is tied low and response codes are ignored.
module axi4m_burst #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // write address channel
    output logic [AXI_ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic [3:0]                m_axi_awqos,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    // write data channel
    output logic [AXI_DATA_W-1:0]     m_axi_wdata,
    output logic [AXI_DATA_W/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    // write response channel
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    // read address channel
    output logic [AXI_ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // read data channel
    input  logic [AXI_DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    // native command
    input  logic                      cmd_val,
    output logic                      cmd_rdy,
    input  logic [AXI_ADDR_W-1:0]     cmd_adr,
    input  logic                      cmd_wr,
    input  logic [LEN_W-1:0]          cmd_len,
    // native write beats
    input  logic                      wd_val,
    output logic                      wd_rdy,
    input  logic [AXI_DATA_W-1:0]     wd_dat,
    input  logic [AXI_DATA_W/8-1:0]   wd_stb,
    // native read beats
    output logic                      rd_val,
    input  logic                      rd_rdy,
    output logic [AXI_DATA_W-1:0]     rd_dat,
    output logic                      rd_last,
    // completion
    output logic                      done,
    output logic                      err
);

    typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA} state_t;

    localparam logic [2:0]     BEAT_SIZE = 3'($clog2(AXI_DATA_W/8));
    localparam logic [LEN_W:0] CNT_ONE   = (LEN_W+1)'(1);

    state_t                state_reg;
    logic [AXI_ADDR_W-1:0] adr_reg;
    logic [LEN_W-1:0]      len_reg;
    // one bit wider than len so an overlong read burst cannot wrap to len
    logic [LEN_W:0]        cnt_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;
    logic                  awvalid_reg;
    logic                  arvalid_reg;
    logic                  done_reg;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic at_len;
    logic w_active;

    // response fields only partly consumed depending on build
    logic unused_resp;
    assign unused_resp = &{1'b0, m_axi_bresp, m_axi_rresp};

    assign at_len   = (cnt_reg == {1'b0, len_reg});
    assign w_active = (state_reg == WR) && !w_done_reg;

    assign aw_hs = awvalid_reg && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;
    assign ar_hs = arvalid_reg && m_axi_arready;
    assign r_hs  = m_axi_rvalid && m_axi_rready;

    // address channel fields: constant attributes, latched address/length
    assign m_axi_awaddr  = adr_reg;
    assign m_axi_awlen   = 8'(len_reg);
    assign m_axi_awsize  = BEAT_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0010;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_reg;

    assign m_axi_araddr  = adr_reg;
    assign m_axi_arlen   = 8'(len_reg);
    assign m_axi_arsize  = BEAT_SIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0010;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = arvalid_reg;

    // write beats pass straight through, gated off once the last beat is taken
    assign m_axi_wdata  = wd_dat;
    assign m_axi_wstrb  = wd_stb;
    assign m_axi_wlast  = at_len;
    assign m_axi_wvalid = w_active && wd_val;
    assign wd_rdy       = w_active && m_axi_wready;

    assign m_axi_bready = (state_reg == WRESP);

    // read beats pass straight through while the burst is open
    assign rd_val       = (state_reg == RDATA) && m_axi_rvalid;
    assign m_axi_rready = (state_reg == RDATA) && rd_rdy;
    assign rd_dat       = m_axi_rdata;
    assign rd_last      = m_axi_rlast;

    assign cmd_rdy = (state_reg == IDLE);
    assign done    = done_reg;

`ifdef AXI4M_BURST_RESP_ERR_EN
    logic err_reg;
    logic err_acc_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // burst sequencer: command latch, address/data phase tracking, completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            adr_reg     <= '0;
            len_reg     <= '0;
            cnt_reg     <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            arvalid_reg <= 1'b0;
            done_reg    <= 1'b0;
`ifdef AXI4M_BURST_RESP_ERR_EN
            err_reg     <= 1'b0;
            err_acc_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_val) begin
                        adr_reg     <= cmd_adr;
                        len_reg     <= cmd_len;
                        cnt_reg     <= '0;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
`ifdef AXI4M_BURST_RESP_ERR_EN
                        err_reg     <= 1'b0;
                        err_acc_reg <= 1'b0;
`endif
                        if (cmd_wr) begin
                            state_reg   <= WR;
                            awvalid_reg <= 1'b1;
                        end else begin
                            state_reg   <= RADDR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        if (at_len) begin
                            w_done_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                    // both the address and the final data beat must be through
                    if ((w_done_reg || (w_hs && at_len)) && (aw_done_reg || aw_hs)) begin
                        state_reg <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
`ifdef AXI4M_BURST_RESP_ERR_EN
                        err_reg   <= err_acc_reg || m_axi_bresp[1];
`endif
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        arvalid_reg <= 1'b0;
                        state_reg   <= RDATA;
                    end
                end
                RDATA: begin
                    if (r_hs) begin
                        if (!(&cnt_reg)) begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                        if (m_axi_rlast) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
`ifdef AXI4M_BURST_RESP_ERR_EN
                            err_reg   <= err_acc_reg || m_axi_rresp[1] || !at_len;
`endif
                        end
`ifdef AXI4M_BURST_RESP_ERR_EN
                        else begin
                            err_acc_reg <= err_acc_reg || m_axi_rresp[1];
                        end
`endif
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4m_burst.sv
// Scoreboard bench for axi4m_burst: stimulus pushes expected AW/AR/W/read-beat/
// completion records; a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_axi4m_burst;

`ifdef AXI4M_BURST_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk, rst;
    logic [31:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        cmd_val, cmd_rdy, cmd_wr;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_len;
    logic        wd_val, wd_rdy;
    logic [31:0] wd_dat;
    logic [3:0]  wd_stb;
    logic        rd_val, rd_rdy, rd_last;
    logic [31:0] rd_dat;
    logic        done, err;

    axi4m_burst #(.AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_adr(cmd_adr), .cmd_wr(cmd_wr), .cmd_len(cmd_len),
        .wd_val(wd_val), .wd_rdy(wd_rdy), .wd_dat(wd_dat), .wd_stb(wd_stb),
        .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_dat(rd_dat), .rd_last(rd_last),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // scoreboard queues
    logic [39:0] exp_aw[$];
    logic [39:0] exp_ar[$];
    logic [36:0] exp_w[$];
    logic [32:0] exp_rd[$];
    logic        exp_done[$];

    int acc_cyc, done_cyc, aw_hs_cyc, b_hs_cyc, wlast_cyc;
    int done_cnt = 0;

    localparam logic [16:0] ATTR = {3'd2, 2'b01, 4'b0010, 1'b0, 3'b000, 4'b0000};

    // monitor: compare every handshake against the head of its queue
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_val && cmd_rdy) acc_cyc = cyc;
            if (m_axi_bvalid && m_axi_bready) b_hs_cyc = cyc;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_hs_cyc = cyc;
                chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
                if (exp_aw.size() != 0) begin
                    chk("aw_len_addr", {m_axi_awlen, m_axi_awaddr}, exp_aw.pop_front());
                    chk("aw_attr", {m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awlock,
                                    m_axi_awprot, m_axi_awqos}, ATTR);
                end
            end
            if (m_axi_arvalid && m_axi_arready) begin
                chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
                if (exp_ar.size() != 0) begin
                    chk("ar_len_addr", {m_axi_arlen, m_axi_araddr}, exp_ar.pop_front());
                    chk("ar_attr", {m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arlock,
                                    m_axi_arprot, m_axi_arqos}, ATTR);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wlast) wlast_cyc = cyc;
                chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
                if (exp_w.size() != 0)
                    chk("w_last_strb_data", {m_axi_wlast, m_axi_wstrb, m_axi_wdata}, exp_w.pop_front());
            end
            if (rd_val && rd_rdy) begin
                chk("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
                if (exp_rd.size() != 0)
                    chk("rd_last_data", {rd_last, rd_dat}, exp_rd.pop_front());
            end
            if (done) begin
                done_cyc = cyc;
                done_cnt++;
                chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
                if (exp_done.size() != 0) chk("done_err", err, exp_done.pop_front());
                chk("done_cmd_rdy", cmd_rdy, 1'b1);
            end
        end
    end

    // write-side slave model
    int  aw_mode = 0;      // 0: awready high, 1: 10 cycles after last W, 2: never
    logic [1:0] bresp_cfg = 2'b00;
    initial begin
        bit s_rst, s_aw, s_wl, s_b, aw_got, w_got;
        int dly;
        aw_got = 0; w_got = 0; dly = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_aw  = m_axi_awvalid && m_axi_awready;
            s_wl  = m_axi_wvalid && m_axi_wready && m_axi_wlast;
            s_b   = m_axi_bvalid && m_axi_bready;
            @(posedge clk); #1;
            if (s_rst) begin
                aw_got = 0; w_got = 0; dly = 0; m_axi_bvalid = 1'b0;
            end else begin
                if (s_b) begin
                    m_axi_bvalid = 1'b0; aw_got = 0; w_got = 0; dly = 0;
                end
                if (s_aw) aw_got = 1;
                if (s_wl) w_got = 1;
                if (w_got) dly++;
                if (aw_got && w_got && !m_axi_bvalid) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bresp  = bresp_cfg;
                end
            end
            m_axi_awready = (aw_mode == 0) ? 1'b1 : (aw_mode == 1) ? (w_got && dly >= 10) : 1'b0;
            m_axi_wready  = 1'b1;
        end
    end

    // read-side slave model and read-beat consumer
    int  rlast_at = 0;
    logic [31:0] r_base = 0;
    bit  rd_toggle = 0;
    initial begin
        bit s_rst, s_ar, s_r, active;
        int idx;
        active = 0; idx = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = 2'b00; rd_rdy = 1'b0;
        forever begin
            @(negedge clk);
            s_rst = rst;
            s_ar  = m_axi_arvalid && m_axi_arready;
            s_r   = m_axi_rvalid && m_axi_rready;
            @(posedge clk); #1;
            if (s_rst) begin
                active = 0; m_axi_rvalid = 1'b0;
            end else begin
                if (s_r) begin
                    if (m_axi_rlast) begin
                        m_axi_rvalid = 1'b0; active = 0;
                    end else begin
                        idx++;
                        m_axi_rdata = r_base + 32'(idx);
                        m_axi_rlast = (idx == rlast_at);
                    end
                end
                if (s_ar) begin
                    active = 1; idx = 0;
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = r_base;
                    m_axi_rlast  = (rlast_at == 0);
                end
            end
            m_axi_arready = !active;
            rd_rdy = rd_toggle ? !rd_rdy : 1'b1;
        end
    end

    task automatic issue_cmd(input logic [31:0] a, input logic w, input logic [3:0] l);
        bit got;
        got = 0;
        cmd_adr = a; cmd_wr = w; cmd_len = l; cmd_val = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = cmd_rdy;
            @(posedge clk); #1;
        end
        cmd_val = 1'b0;
        chk("cmd_accepted", 64'(got), 64'd1);
    endtask

    task automatic wait_done(input int start_cnt);
        for (int t = 0; t < 300 && done_cnt == start_cnt; t++) begin
            @(posedge clk); #1;
        end
        chk("done_count", 64'(done_cnt), 64'(start_cnt + 1));
    endtask

    task automatic feed_w(input logic [3:0] len, input logic [31:0] base, input logic [3:0] strb);
        int i;
        bit hs;
        i = 0;
        for (int t = 0; t < 300 && i <= int'(len); t++) begin
            wd_val = 1'b1; wd_dat = base + 32'(i); wd_stb = strb;
            @(negedge clk);
            hs = wd_val && wd_rdy;
            @(posedge clk); #1;
            if (hs) i++;
        end
        wd_val = 1'b0;
        chk("w_beats_fed", 64'(i), 64'(int'(len) + 1));
    endtask

    task automatic run_write(input logic [31:0] adr, input logic [3:0] len, input logic [31:0] base,
                             input logic [3:0] strb, input logic [1:0] resp);
        int n;
        bresp_cfg = resp;
        exp_aw.push_back({4'b0, len, adr});
        for (int i = 0; i <= int'(len); i++)
            exp_w.push_back({(i == int'(len)), strb, base + 32'(i)});
        exp_done.push_back(ERR_EN && resp[1]);
        n = done_cnt;
        issue_cmd(adr, 1'b1, len);
        feed_w(len, base, strb);
        wait_done(n);
    endtask

    task automatic run_read(input logic [31:0] adr, input logic [3:0] len, input int last_at,
                            input logic [31:0] base);
        int n;
        rlast_at = last_at; r_base = base;
        exp_ar.push_back({4'b0, len, adr});
        for (int i = 0; i <= last_at; i++)
            exp_rd.push_back({(i == last_at), base + 32'(i)});
        exp_done.push_back(ERR_EN && (last_at != int'(len)));
        n = done_cnt;
        issue_cmd(adr, 1'b0, len);
        wait_done(n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; cmd_val = 1'b0; cmd_adr = '0; cmd_wr = 1'b0; cmd_len = '0;
        wd_val = 1'b1; wd_dat = '0; wd_stb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_rdy", cmd_rdy, 1'b1);
        chk("rst_awvalid", m_axi_awvalid, 1'b0);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_wvalid", m_axi_wvalid, 1'b0);
        chk("rst_wd_rdy", wd_rdy, 1'b0);
        chk("rst_bready", m_axi_bready, 1'b0);
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_rd_val", rd_val, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; wd_val = 1'b0;
        repeat (2) @(posedge clk); #1;

        // single-beat write, done three cycles after acceptance
        run_write(32'h100, 4'd0, 32'hDEADBEEF, 4'hF, 2'b00);
        chk("t1_done_latency", 64'(done_cyc - acc_cyc), 64'd3);

        // 4-beat read with a stalling consumer
        rd_toggle = 1;
        run_read(32'h2000, 4'd3, 3, 32'd0);
        rd_toggle = 0;
        repeat (2) @(posedge clk); #1;

        // 8-beat write, address accepted long after the data
        aw_mode = 1;
        run_write(32'h3000, 4'd7, 32'h1000, 4'hF, 2'b00);
        chk("t3_aw_after_w", 64'((aw_hs_cyc - wlast_cyc) >= 10), 64'd1);
        chk("t3_b_after_aw", 64'(b_hs_cyc > aw_hs_cyc), 64'd1);
        aw_mode = 0;

        // slave error response, then a clean write clears err
        run_write(32'h4000, 4'd1, 32'h55, 4'h3, 2'b10);
        run_write(32'h4100, 4'd2, 32'hA0, 4'hC, 2'b00);

        // early rlast terminates the burst after two beats
        run_read(32'h5000, 4'd3, 1, 32'h77);

        // reset during beat 2 of an 8-beat write
        aw_mode = 2;
        for (int i = 0; i < 3; i++) exp_w.push_back({1'b0, 4'hF, 32'h900 + 32'(i)});
        n = done_cnt;
        issue_cmd(32'h6000, 1'b1, 4'd7);
        wd_val = 1'b1; wd_stb = 4'hF;
        wd_dat = 32'h900; @(posedge clk); #1;
        wd_dat = 32'h901; @(posedge clk); #1;
        wd_dat = 32'h902; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_awvalid_low", m_axi_awvalid, 1'b0);
        chk("t6_wvalid_low", m_axi_wvalid, 1'b0);
        chk("t6_idle", cmd_rdy, 1'b1);
        wd_val = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("t6_no_done", 64'(done_cnt), 64'(n));
        aw_mode = 0;
        repeat (2) @(posedge clk); #1;
        run_write(32'h7000, 4'd3, 32'hB00, 4'hF, 2'b00);
        run_read(32'h8000, 4'd0, 0, 32'hCAFE0000);
        chk("t7_read_latency", 64'(done_cyc - acc_cyc), 64'd3);

        repeat (3) @(posedge clk);
        chk("left_aw", 64'(exp_aw.size()), 64'd0);
        chk("left_ar", 64'(exp_ar.size()), 64'd0);
        chk("left_w", 64'(exp_w.size()), 64'd0);
        chk("left_rd", 64'(exp_rd.size()), 64'd0);
        chk("left_done", 64'(exp_done.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
